// File: rtl/rot_pkg.sv
// Shared types and ASCII constants for the rotation command parser.
package rot_pkg;

  localparam int unsigned DIS_W_DEF = 10;

  typedef enum logic [1:0] {
    StIdle,
    StDigits,
    StSkip,
    StEmit
  } state_e;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal accumulator with sticky overflow; value saturates to all-ones once overflowed.
module dec_accum #(
  parameter int unsigned DIS_W = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [3:0]       digit,
  output logic [DIS_W-1:0] value,
  output logic             ovf
);

  localparam int unsigned AW = DIS_W + 4;
  localparam logic [AW-1:0] MaxVal = {4'b0000, {DIS_W{1'b1}}};

  logic [AW-1:0] acc_q, acc_d, prod;
  logic          ovf_q, ovf_d;

  always_comb begin
    // acc never exceeds MaxVal, so acc*10+9 always fits in AW bits
    prod  = (acc_q << 3) + (acc_q << 1) + {{DIS_W{1'b0}}, digit};
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (load && !ovf_q) begin
      if (prod > MaxVal) begin
        ovf_d = 1'b1;
      end else begin
        acc_d = prod;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign value = ovf_q ? {DIS_W{1'b1}} : acc_q[DIS_W-1:0];
  assign ovf   = ovf_q;

endmodule

// File: rtl/rotation_cmd_parser.sv
// ASCII "L68\n" line parser emitting (dirn, dis) commands; malformed lines dropped and counted.
// ROT_PARSER_SATURATE_EN: emit overflowed distances as all-ones instead of dropping the line.
module rotation_cmd_parser
  import rot_pkg::*;
#(
  parameter int unsigned DIS_W = DIS_W_DEF,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_dirn,
  output logic [DIS_W-1:0] out_dis,
  output logic [CNT_W-1:0] cmd_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_pulse
);

`ifdef ROT_PARSER_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic             dirn_q, dirn_d;
  logic             seen_q, seen_d;
  logic             err_q, err_d;
  logic             cmd_inc;
  logic             acc_clr, acc_load, acc_ovf;
  logic             byte_ok;
  logic [CNT_W-1:0] cmd_q, errc_q;

  assign byte_ok = in_valid && in_ready;

  dec_accum #(
    .DIS_W(DIS_W)
  ) u_accum (
    .clk  (clk),
    .rstn (rstn),
    .clr  (acc_clr),
    .load (acc_load),
    .digit(in_data[3:0]),
    .value(out_dis),
    .ovf  (acc_ovf)
  );

  always_comb begin
    state_d  = state_q;
    dirn_d   = dirn_q;
    seen_d   = seen_q;
    err_d    = 1'b0;
    acc_clr  = 1'b0;
    acc_load = 1'b0;
    cmd_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (byte_ok) begin
          if (in_data == CH_L || in_data == CH_R) begin
            dirn_d  = (in_data == CH_R);
            seen_d  = 1'b0;
            acc_clr = 1'b1;
            state_d = StDigits;
          end else if (in_data != CH_LF && in_data != CH_CR && in_data != CH_SP) begin
            err_d   = 1'b1;
            state_d = StSkip;
          end
        end
      end
      StDigits: begin
        if (byte_ok) begin
          if (is_digit(in_data)) begin
            acc_load = 1'b1;
            seen_d   = 1'b1;
          end else if (in_data == CH_LF) begin
            if (!seen_q || (acc_ovf && !SatEn)) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StEmit;
            end
          end else if (in_data != CH_CR) begin
            err_d   = 1'b1;
            state_d = StSkip;
          end
        end
      end
      StSkip: begin
        if (byte_ok && in_data == CH_LF) state_d = StIdle;
      end
      StEmit: begin
        if (out_ready) begin
          cmd_inc = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      dirn_q  <= 1'b0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
      cmd_q   <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      dirn_q  <= dirn_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      if (cmd_inc) cmd_q <= cmd_q + 1'b1;
      if (err_d) errc_q <= errc_q + 1'b1;
    end
  end

  assign in_ready  = (state_q != StEmit);
  assign out_valid = (state_q == StEmit);
  assign out_dirn  = dirn_q;
  assign cmd_count = cmd_q;
  assign err_count = errc_q;
  assign err_pulse = err_q;

endmodule
